// File: rtl/multi_event_counter_pkg.sv
// rtl/multi_event_counter_pkg.sv - shared types and sizing helpers for the multi-channel event counter
package multi_event_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_STORE = 2'd2
   } bcd_state_e;

   // Decimal digits needed to show the largest unsigned value of the given width.
   function automatic int bcd_digits_needed(input int width);
      longint unsigned maxv;
      int              d;
      maxv = (64'd1 << width) - 64'd1;
      d    = 1;
      maxv = maxv / 64'd10;
      while (maxv != 64'd0) begin
         d++;
         maxv = maxv / 64'd10;
      end
      return d;
   endfunction

   // Bits needed to hold an index 0..n-1 (never less than 1).
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - two-flop synchroniser, debounce filter and registered rising-edge pulse
module debounce_edge
   import multi_event_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_i,
   output logic rise_o
);

   localparam int DB_W = idx_width(DEBOUNCE_CYCLES);

   logic            sync1_q;
   logic            sync2_q;
   logic            stable_q;
   logic            stable_dly_q;
   logic            rise_q;
   logic [DB_W-1:0] db_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         rise_q       <= 1'b0;
         db_cnt_q     <= '0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         // Any return to the stable level clears the run, so glitches restart the wait.
         if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               stable_q <= sync2_q;
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + DB_W'(1);
            end
         end else begin
            db_cnt_q <= '0;
         end
         stable_dly_q <= stable_q;
         rise_q       <= stable_q & ~stable_dly_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/multi_event_counter.sv
// rtl/multi_event_counter.sv - per-channel debounced up/down counters with a shared round-robin BCD converter
module multi_event_counter
   import multi_event_counter_pkg::*;
#(
   parameter int CHANNELS        = 2,
   parameter int CNT_W           = 16,
   parameter int DIGITS          = 5,
   parameter int DEBOUNCE_CYCLES = 2500000,
   parameter int WRAP            = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS-1:0]          sw_in,
   input  logic                         down,
   input  logic [CHANNELS-1:0]          clear,
   output logic [CHANNELS*CNT_W-1:0]    count_out,
   output logic [CHANNELS*4*DIGITS-1:0] bcd_out,
   output logic [CHANNELS-1:0]          bcd_valid,
   output logic [CHANNELS-1:0]          ovf
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + CNT_W;
   localparam int CH_W  = idx_width(CHANNELS);
   localparam int SC_W  = idx_width(CNT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (bcd_digits_needed(CNT_W) > DIGITS) begin : g_bad_digits
      $error("DIGITS cannot represent the full CNT_W range");
   end
   if (CHANNELS < 1 || CHANNELS > 8 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
      $error("CHANNELS must be 1..8 and DEBOUNCE_CYCLES at least 2");
   end

   logic [CHANNELS-1:0] rise;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      debounce_edge #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .rst_n (rst_n),
         .sw_i  (sw_in[k]),
         .rise_o(rise[k])
      );
   end

   logic [CHANNELS-1:0][CNT_W-1:0] count_q, count_d;
   logic [CHANNELS-1:0]            ovf_q, ovf_d;

   // Clear wins over a coincident edge; the edge is dropped, not deferred.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      for (int k = 0; k < CHANNELS; k++) begin
         if (clear[k]) begin
            count_d[k] = '0;
            ovf_d[k]   = 1'b0;
         end else if (rise[k]) begin
            if (!down) begin
               if (count_q[k] == CNT_MAX) begin
                  ovf_d[k] = 1'b1;
                  if (WRAP != 0) count_d[k] = '0;
               end else begin
                  count_d[k] = count_q[k] + CNT_W'(1);
               end
            end else begin
               if (count_q[k] == '0) begin
                  ovf_d[k] = 1'b1;
                  if (WRAP != 0) count_d[k] = CNT_MAX;
               end else begin
                  count_d[k] = count_q[k] - CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= '0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   bcd_state_e                     state_q;
   logic [CH_W-1:0]                ch_q;
   logic [SC_W-1:0]                sc_q;
   logic [SR_W-1:0]                sr_q;
   logic [SR_W-1:0]                sr_adj;
   logic [CHANNELS-1:0][BCD_W-1:0] bcd_q;
   logic [CHANNELS-1:0]            valid_q;

   // Double-dabble correction: nibbles of 5 or more would exceed 9 once doubled.
   always_comb begin
      sr_adj = sr_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (sr_q[CNT_W + 4*d +: 4] >= 4'd5) begin
            sr_adj[CNT_W + 4*d +: 4] = sr_q[CNT_W + 4*d +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         sc_q    <= '0;
         sr_q    <= '0;
         bcd_q   <= '0;
         valid_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sr_q    <= {{BCD_W{1'b0}}, count_q[ch_q]};
               sc_q    <= '0;
               state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               sr_q <= sr_adj << 1;
               if (sc_q == SC_W'(CNT_W - 1)) begin
                  state_q <= ST_STORE;
               end else begin
                  sc_q <= sc_q + SC_W'(1);
               end
            end
            ST_STORE: begin
               bcd_q[ch_q]   <= sr_q[SR_W-1 -: BCD_W];
               valid_q[ch_q] <= 1'b1;
               ch_q          <= (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
               state_q       <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign count_out = count_q;
   assign ovf       = ovf_q;
   assign bcd_out   = bcd_q;
   assign bcd_valid = valid_q;

endmodule
